p2s_lane_tx: RTL and testbench
==============================

Name: p2s_lane_tx

Overview:
- Four-lane parallel-to-serial transmitter. Directly upstream of the per-lane serial-to-parallel receivers; its S_OUT bits drive their S_IN inputs.
- Accepts one 32-bit word through a valid/ready handshake and splits it into one byte per lane.
- Shifts all four bytes out in lockstep, one bit per CLK.
- A one-entry pending buffer lets words stream back to back with no idle cycles between bytes.

Parameters:
- LANES, 4, number of serial lanes.
- WIDTH, 8, bits per lane per word (byte length).
- IDLE_BIT, 1'b0, value driven on every lane when no word is being shifted.

Ports:
- CLK  input  1  single clock for the whole block; everything is sampled on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ENB  input  1  global enable; when low, all state freezes.
- DIR  input  1  bit order: 0 sends MSB first, 1 sends LSB first; sampled when a word is accepted.
- D_IN  input  LANES*WIDTH  input word; lane k carries D_IN[WIDTH*k+WIDTH-1 : WIDTH*k].
- VALID  input  1  D_IN and DIR are valid this cycle.
- READY  output  1  block can accept a word this cycle.
- S_OUT  output  LANES  serial bit per lane; bit k feeds lane k.
- FRAME  output  1  high during the first bit of each byte.
- BUSY  output  1  a byte is currently being shifted.

Behaviour:
- Reset (async, takes effect immediately, overrides ENB):
  - S_OUT = {LANES{IDLE_BIT}}, FRAME = 0, BUSY = 0, READY = 1.
  - Bit counter = 0, active register empty, pending buffer empty, latched DIR = 0.
- Storage:
  - Active shift register: LANES x WIDTH, with its own latched DIR and a bit counter of width clog2(WIDTH).
  - Pending buffer: one word plus its DIR.
- Handshake:
  - READY = ENB && !pending_full. READY is combinational from registered state only; it never depends on VALID.
  - A word is accepted at a rising edge where VALID && READY. The holder keeps D_IN/VALID stable until accepted.
- Where an accepted word goes:
  - If the active register is empty, or finishes its last bit on that same edge: the word loads straight into the active register.
  - Otherwise it goes into the pending buffer.
- At the last-bit edge (counter == WIDTH-1):
  - If the pending buffer is full, its word moves to active and pending empties. READY was already 0 that cycle, so no new word is accepted.
  - Else if a word is accepted on that edge, it loads into active.
  - Else active becomes empty.
- S_OUT (registered):
  - Bit k = head bit of lane k's active byte: bit WIDTH-1-cnt when DIR=0, bit cnt when DIR=1.
  - When active is empty, S_OUT = IDLE_BIT.
- Latency: a word accepted at edge N into empty active presents bit 0 of the sequence during cycle N+1 (after edge N). Its last bit appears in cycle N+WIDTH.
- Back to back: byte i+1's first bit directly follows byte i's last bit, with no gap.
- FRAME = 1 exactly in cycles where cnt == 0 and active is valid.
- BUSY = active valid.
- ENB = 0:
  - Counter, shift register, pending buffer and outputs all hold their values.
  - READY = 0; no word is accepted.
  - When ENB returns high, the counter resumes from where it stopped.
- DIR is latched per word. Changing DIR mid-byte does not affect the byte in flight.
- Counter wraps from WIDTH-1 to 0 only when a new word loads into active. Otherwise it returns to 0 and holds there in idle.
- Reset mid-byte: the byte in flight and the pending word are both dropped, and outputs return to their reset values immediately.

Test Plan:
- Reset check: assert reset asynchronously between edges -> S_OUT=4'b0000, READY=1, BUSY=0 and FRAME=0 with no clock edge needed.
- MSB-first word: D_IN=32'hA5C3F081, DIR=0, one-cycle VALID.
  - Over 8 cycles, lane3 sends 1,0,1,0,0,1,0,1; lane0 sends 1,0,0,0,0,0,0,1.
  - FRAME=1 in the first cycle only; BUSY drops after 8 cycles and S_OUT returns to 0.
- LSB-first word: same word with DIR=1.
  - lane1 (8'hF0) sends 0,0,0,0,1,1,1,1; lane2 (8'hC3) sends 1,1,0,0,0,0,1,1.
- Streaming: three words with VALID held high.
  - READY drops after the second accept and rises again at the first byte's last-bit edge.
  - 24 consecutive bits with no gap; FRAME pulses at cycles 1, 9 and 17.
- Enable stall: ENB low for 5 cycles at bit 3 of a byte.
  - S_OUT, FRAME and BUSY hold; READY=0; no word is accepted even with VALID=1.
  - After ENB returns high, bits 4..7 follow unchanged.
- Reset mid-operation: reset asserted at bit 4 with the pending buffer full.
  - Outputs return to reset values immediately.
  - After release, the next accepted word starts cleanly with FRAME=1 and never sends the dropped pending word.

Source files
------------

// File: rtl/p2s_lane_tx.sv
// Four-lane parallel-to-serial transmitter: one 32-bit word is accepted per handshake
// and shifted out one bit per lane per clock, with a one-word pending buffer for streaming.
module p2s_lane_tx #(
  parameter int   LANES    = 4,
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   ENB,
  input  logic                   DIR,
  input  logic [LANES*WIDTH-1:0] D_IN,
  input  logic                   VALID,
  output logic                   READY,
  output logic [LANES-1:0]       S_OUT,
  output logic                   FRAME,
  output logic                   BUSY
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [LANES*WIDTH-1:0] act_data, act_data_nxt, pend_data;
  logic                   act_valid, act_valid_nxt;
  logic                   act_dir, act_dir_nxt;
  logic                   pend_full, pend_full_nxt, pend_dir, pend_wr;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   accept, last_bit;

  // Picks the current head bit of every lane's byte for the given bit order.
  function automatic logic [LANES-1:0] head_bits(input logic [LANES*WIDTH-1:0] data,
                                                 input logic dir, input logic [CW-1:0] c);
    logic [LANES-1:0] bits;
    int               idx;
    idx = dir ? int'(c) : (WIDTH - 1 - int'(c));
    for (int k = 0; k < LANES; k++) bits[k] = data[WIDTH*k + idx];
    return bits;
  endfunction

  assign READY    = ENB && !pend_full;
  assign accept   = VALID && READY;
  assign last_bit = act_valid && (cnt == LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    act_valid_nxt = act_valid;
    act_data_nxt  = act_data;
    act_dir_nxt   = act_dir;
    cnt_nxt       = cnt;
    pend_full_nxt = pend_full;
    pend_wr       = 1'b0;
    if (!act_valid || last_bit) begin
      cnt_nxt = '0;
      if (pend_full) begin
        act_valid_nxt = 1'b1;
        act_data_nxt  = pend_data;
        act_dir_nxt   = pend_dir;
        pend_full_nxt = 1'b0;
      end else if (accept) begin
        act_valid_nxt = 1'b1;
        act_data_nxt  = D_IN;
        act_dir_nxt   = DIR;
      end else begin
        act_valid_nxt = 1'b0;
      end
    end else begin
      cnt_nxt = cnt + 1'b1;
      if (accept) begin
        pend_full_nxt = 1'b1;
        pend_wr       = 1'b1;
      end
    end
  end

  // Outputs are registered from next state so a loaded word shows its first bit right after the accepting edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are cleared too so a dropped word can never resurface after reset.
      act_valid <= 1'b0;
      act_data  <= '0;
      act_dir   <= 1'b0;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_dir  <= 1'b0;
      S_OUT     <= {LANES{IDLE_BIT}};
      FRAME     <= 1'b0;
      BUSY      <= 1'b0;
    end else if (ENB) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      act_valid <= act_valid_nxt;
      act_data  <= act_data_nxt;
      act_dir   <= act_dir_nxt;
      cnt       <= cnt_nxt;
      pend_full <= pend_full_nxt;
      if (pend_wr) begin
        pend_data <= D_IN;
        pend_dir  <= DIR;
      end
      S_OUT <= act_valid_nxt ? head_bits(act_data_nxt, act_dir_nxt, cnt_nxt) : {LANES{IDLE_BIT}};
      FRAME <= act_valid_nxt && (cnt_nxt == '0);
      BUSY  <= act_valid_nxt;
    end
  end

endmodule

// File: tb/tb_p2s_lane_tx.sv
// Scoreboard bench for p2s_lane_tx: stimulus pushes expected per-cycle lane bits,
// a negedge monitor pops and compares whenever the transmitter is busy.
module tb_p2s_lane_tx;

  logic        CLK   = 1'b0;
  logic        reset = 1'b0;
  logic        ENB   = 1'b1;
  logic        DIR   = 1'b0;
  logic        VALID = 1'b0;
  logic [31:0] D_IN  = '0;
  logic        READY;
  logic [3:0]  S_OUT;
  logic        FRAME;
  logic        BUSY;

  p2s_lane_tx #(.LANES(4), .WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .CLK(CLK), .reset(reset), .ENB(ENB), .DIR(DIR), .D_IN(D_IN),
    .VALID(VALID), .READY(READY), .S_OUT(S_OUT), .FRAME(FRAME), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] s;
    logic       f;
  } beat_t;

  beat_t sb[$];
  beat_t last_beat = '0;
  logic  adv = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Hand-computed S_OUT per cycle for 32'hA5C3F081 sent MSB first (lanes 3..0 = A5,C3,F0,81).
  logic [3:0] hand_msb [8] = '{4'hF, 4'h6, 4'hA, 4'h2, 4'h0, 4'h8, 4'h4, 4'hD};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic d);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      if (w == 32'hA5C3F081) begin
        b.s = d ? hand_msb[7-i] : hand_msb[i];
      end else begin
        for (int k = 0; k < 4; k++) b.s[k] = w[8*k + (d ? i : 7 - i)];
      end
      b.f = (i == 0);
      sb.push_back(b);
    end
  endtask

  // Presents a word and holds it until accepted; returns how many cycles were polled.
  task automatic send(input logic [31:0] w, input logic d, output int polls);
    logic done;
    done  = 1'b0;
    D_IN  = w;
    DIR   = d;
    VALID = 1'b1;
    polls = 0;
    while (!done && polls < 50) begin
      @(negedge CLK);
      polls++;
      if (READY) begin
        @(posedge CLK);
        push_word(w, d);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      check("accept_timeout", 32'(polls), 32'd0);
      VALID = 1'b0;
    end
  endtask

  always @(posedge CLK) adv <= ENB && !reset;

  always @(negedge CLK) begin
    if (!reset) begin
      if (BUSY && adv) begin
        if (sb.size() == 0) begin
          check("unexpected_busy", 32'(BUSY), 32'd0);
        end else begin
          last_beat = sb.pop_front();
          check("beat", 32'({S_OUT, FRAME}), 32'(last_beat));
        end
      end else if (BUSY) begin
        check("stall_hold", 32'({S_OUT, FRAME}), 32'(last_beat));
      end else if (adv) begin
        check("idle_out", 32'({S_OUT, FRAME}), 32'd0);
        check("gap", 32'(sb.size()), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;

    // Asynchronous reset between edges, before any clock edge has occurred.
    #1 reset = 1'b1;
    #2;
    check("rst_s_out", 32'(S_OUT), 32'd0);
    check("rst_ready", 32'(READY), 32'd1);
    check("rst_busy",  32'(BUSY),  32'd0);
    check("rst_frame", 32'(FRAME), 32'd0);
    @(negedge CLK) reset = 1'b0;
    @(posedge CLK) #1;

    // MSB-first word then LSB-first word.
    send(32'hA5C3F081, 1'b0, p);
    VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("msb_done_busy", 32'(BUSY), 32'd0);
    check("msb_done_s_out", 32'(S_OUT), 32'd0);

    send(32'hA5C3F081, 1'b1, p);
    VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("lsb_done_busy", 32'(BUSY), 32'd0);

    // Streaming three words with VALID held high.
    send(32'h12345678, 1'b0, p);
    check("stream_ready_1", 32'(READY), 32'd1);
    send(32'hDEADBEEF, 1'b1, p);
    check("stream_ready_2", 32'(READY), 32'd0);
    send(32'hA5C3F081, 1'b0, p);
    check("stream_wait_polls", 32'(p), 32'd8);
    VALID = 1'b0;
    repeat (20) @(posedge CLK);
    #1;

    // Enable stall for 5 cycles while bit 3 is on the lanes.
    send(32'h3C5A96F0, 1'b0, p);
    VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    ENB   = 1'b0;
    VALID = 1'b1;
    D_IN  = 32'hFFFFFFFF;
    repeat (5) begin
      @(negedge CLK);
      check("stall_ready", 32'(READY), 32'd0);
      check("stall_busy",  32'(BUSY),  32'd1);
      @(posedge CLK);
      #1;
    end
    VALID = 1'b0;
    ENB   = 1'b1;
    repeat (12) @(posedge CLK);
    #1;

    // Reset mid-byte with the pending buffer full.
    send(32'h0F1E2D3C, 1'b0, p);
    send(32'hCAFEF00D, 1'b1, p);
    VALID = 1'b0;
    check("pend_full_ready", 32'(READY), 32'd0);
    repeat (3) @(posedge CLK);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_s_out", 32'(S_OUT), 32'd0);
    check("mid_rst_ready", 32'(READY), 32'd1);
    check("mid_rst_busy",  32'(BUSY),  32'd0);
    check("mid_rst_frame", 32'(FRAME), 32'd0);
    @(posedge CLK) #2 reset = 1'b0;
    @(posedge CLK) #1;
    send(32'h5A5A0FF0, 1'b0, p);
    VALID = 1'b0;
    check("post_rst_frame", 32'(FRAME), 32'd1);
    repeat (20) @(posedge CLK);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(BUSY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
